layer_sequencer: RTL and testbench

//  Parametrised successor to the fixed 4-state engine control FSM. Sequences one layer pass:

---
 rtl/layer_seq_pkg.sv | 18 +
 rtl/beat_counter.sv | 28 ++
 rtl/layer_sequencer.sv | 117 +++++++++++
 tb/tb_layer_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/layer_seq_pkg.sv
// Shared types and helpers for the layer pass sequencer.
package layer_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        COMPUTE = 3'd2,
        READ    = 3'd3,
        DONE    = 3'd4
    } seq_state_t;

    // Saturate a requested beat count to the RAM depth.
    function automatic int unsigned clamp_beats(input int unsigned beats,
                                                input int unsigned max_beats);
        return (beats > max_beats) ? max_beats : beats;
    endfunction

endpackage

// File: rtl/beat_counter.sv
// Beat counter shared by the LOAD and READ phases; wraps to 0 after the last beat.
module beat_counter #(
    parameter  int MAX_BEATS = 16,
    localparam int ADDR_W    = $clog2(MAX_BEATS),
    localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              inc,
    input  logic              clr,
    input  logic [CNT_W-1:0]  limit,
    output logic [ADDR_W-1:0] count,
    output logic              at_last
);

    assign at_last = (CNT_W'(count) == (limit - CNT_W'(1)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= at_last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Layer pass sequencer: LOAD beats, kick and watch the MAC array, READ beats, flag completion.
module layer_sequencer
    import layer_seq_pkg::*;
#(
    parameter  int MAX_BEATS = 16,
    parameter  int TIMEOUT   = 256,
    localparam int ADDR_W    = $clog2(MAX_BEATS),
    localparam int CNT_W     = $clog2(MAX_BEATS + 1),
    localparam int TO_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  cfg_wr_beats,
    input  logic [CNT_W-1:0]  cfg_rd_beats,
    input  logic              in_valid,
    input  logic              out_ready,
    input  logic              compute_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              compute_start,
    output logic              output_ready,
    output logic              done_err,
    output logic              busy,
    output seq_state_t        state_dbg
);

    localparam logic [TO_W-1:0] WD_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    seq_state_t        state, state_next;
    logic [CNT_W-1:0]  wr_beats_q, rd_beats_q, wr_clamped, rd_clamped, beat_limit;
    logic [TO_W-1:0]   wd_cnt;
    logic [ADDR_W-1:0] beat_cnt;
    logic              beat_at_last, beat_last, beat_clr, wd_expire;
    logic              cs_next, or_next, err_next;

    assign wr_clamped = CNT_W'(clamp_beats(32'(cfg_wr_beats), MAX_BEATS));
    assign rd_clamped = CNT_W'(clamp_beats(32'(cfg_rd_beats), MAX_BEATS));

    // Beat handshake: a write beat transfers on every cycle with wr_en (LOAD & in_valid),
    // a read beat on every cycle with rd_en (READ & out_ready); nothing else qualifies a beat.
    assign wr_en   = (state == LOAD) && in_valid;
    assign rd_en   = (state == READ) && out_ready;
    assign wr_addr = (state == LOAD) ? beat_cnt : '0;
    assign rd_addr = (state == READ) ? beat_cnt : '0;

    assign beat_limit = (state == READ) ? rd_beats_q : wr_beats_q;
    assign beat_clr   = abort && (state != IDLE);
    assign beat_last  = (wr_en || rd_en) && beat_at_last;
    assign wd_expire  = (TIMEOUT > 0) && (state == COMPUTE) && (wd_cnt == WD_LAST);
    assign state_dbg  = state;

    beat_counter #(.MAX_BEATS(MAX_BEATS)) u_beat_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (wr_en || rd_en),
        .clr     (beat_clr),
        .limit   (beat_limit),
        .count   (beat_cnt),
        .at_last (beat_at_last)
    );

    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        unique case (state)
            IDLE:    if (start) state_next = (wr_clamped != '0) ? LOAD : COMPUTE;
            LOAD:    if (beat_last) state_next = COMPUTE;
            COMPUTE: begin
                // A done arriving on the expiry cycle still counts as success.
                if (compute_done) begin
                    state_next = (rd_beats_q != '0) ? READ : DONE;
                end else if (wd_expire) begin
                    state_next = DONE;
                    err_next   = 1'b1;
                end
            end
            READ:    if (beat_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort && (state != IDLE)) begin
            state_next = IDLE;
            err_next   = 1'b0;
        end
        cs_next = (state_next == COMPUTE) && (state != COMPUTE);
        or_next = (state_next == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            wr_beats_q    <= '0;
            rd_beats_q    <= '0;
            wd_cnt        <= '0;
            compute_start <= 1'b0;
            output_ready  <= 1'b0;
            done_err      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state <= state_next;
            if ((state == IDLE) && start) begin
                wr_beats_q <= wr_clamped;
                rd_beats_q <= rd_clamped;
            end
            wd_cnt        <= ((state == COMPUTE) && (state_next == COMPUTE)) ? wd_cnt + 1'b1 : '0;
            compute_start <= cs_next;
            output_ready  <= or_next;
            done_err      <= err_next;
            busy          <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed cycle-by-cycle bench for layer_sequencer (MAX_BEATS=16, TIMEOUT=8).
module tb_layer_sequencer;
    import layer_seq_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0, abort = 1'b0;
    logic [4:0] cfg_wr_beats = '0, cfg_rd_beats = '0;
    logic       in_valid = 1'b0, out_ready = 1'b0, compute_done = 1'b0;
    logic       wr_en, rd_en, compute_start, output_ready, done_err, busy;
    logic [3:0] wr_addr, rd_addr;
    seq_state_t state_dbg;
    logic [13:0] obs;

    int vectors = 0;
    int miscompares = 0;

    // Expected-vector layout: {wr_en, wr_addr, rd_en, rd_addr, compute_start, output_ready, done_err, busy}
    localparam logic [13:0] IDLE_V = 14'h0;
    localparam logic [13:0] BZ_V   = {10'h0, 4'b0001};
    localparam logic [13:0] CS_V   = {10'h0, 4'b1001};
    localparam logic [13:0] OR_V   = {10'h0, 4'b0101};
    localparam logic [13:0] ERR_V  = {10'h0, 4'b0111};

    function automatic logic [13:0] wr(input logic [3:0] a);
        return {1'b1, a, 1'b0, 4'h0, 4'b0001};
    endfunction
    function automatic logic [13:0] ld(input logic [3:0] a);
        return {1'b0, a, 1'b0, 4'h0, 4'b0001};
    endfunction
    function automatic logic [13:0] rd(input logic [3:0] a);
        return {1'b0, 4'h0, 1'b1, a, 4'b0001};
    endfunction

    always #5 clk = ~clk;

    assign obs = {wr_en, wr_addr, rd_en, rd_addr, compute_start, output_ready, done_err, busy};

    layer_sequencer #(.MAX_BEATS(16), .TIMEOUT(8)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .abort         (abort),
        .cfg_wr_beats  (cfg_wr_beats),
        .cfg_rd_beats  (cfg_rd_beats),
        .in_valid      (in_valid),
        .out_ready     (out_ready),
        .compute_done  (compute_done),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .compute_start (compute_start),
        .output_ready  (output_ready),
        .done_err      (done_err),
        .busy          (busy),
        .state_dbg     (state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // One clock cycle: inputs change just after the rising edge, outputs checked at the falling edge.
    task automatic step(input logic st, input logic iv, input logic ordy, input logic cd,
                        input logic ab, input logic [13:0] exp, input string tag);
        @(posedge clk);
        #1;
        start        = st;
        in_valid     = iv;
        out_ready    = ordy;
        compute_done = cd;
        abort        = ab;
        @(negedge clk);
        check(tag, 32'(obs), 32'(exp));
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset outputs", 32'(obs), 32'(IDLE_V));
        check("reset state", 32'(state_dbg), 32'(IDLE));
        reset_n = 1'b1;

        // 1: N=4, M=2, done 3 cycles after the kick -> output_ready in cycle 11
        cfg_wr_beats = 5'd4; cfg_rd_beats = 5'd2;
        step(1, 1, 1, 0, 0, IDLE_V, "t1 c0");
        for (int c = 1; c <= 4; c++) step(0, 1, 1, 0, 0, wr(4'(c - 1)), $sformatf("t1 c%0d", c));
        step(0, 1, 1, 0, 0, CS_V, "t1 c5");
        step(0, 1, 1, 0, 0, BZ_V, "t1 c6");
        step(0, 1, 1, 0, 0, BZ_V, "t1 c7");
        step(0, 1, 1, 1, 0, BZ_V, "t1 c8");
        step(0, 1, 1, 0, 0, rd(4'd0), "t1 c9");
        step(0, 1, 1, 0, 0, rd(4'd1), "t1 c10");
        step(0, 1, 1, 0, 0, OR_V, "t1 c11");
        step(0, 1, 1, 0, 0, IDLE_V, "t1 c12");

        // 2: N=4, M=0, in_valid 1010...; compute_done held high from IDLE onward
        cfg_wr_beats = 5'd4; cfg_rd_beats = 5'd0;
        step(1, 0, 1, 1, 0, IDLE_V, "t2 c0");
        for (int c = 1; c <= 7; c++) begin
            if (c % 2 == 1) step(0, 1, 1, 1, 0, wr(4'((c - 1) / 2)), $sformatf("t2 c%0d", c));
            else            step(0, 0, 1, 1, 0, ld(4'(c / 2)), $sformatf("t2 c%0d", c));
        end
        step(0, 0, 1, 1, 0, CS_V, "t2 c8");
        step(0, 0, 1, 0, 0, OR_V, "t2 c9");
        step(0, 0, 1, 0, 0, IDLE_V, "t2 c10");

        // 3: N=0, M=0 -> straight to COMPUTE
        cfg_wr_beats = 5'd0; cfg_rd_beats = 5'd0;
        step(1, 1, 1, 0, 0, IDLE_V, "t3 c0");
        step(0, 1, 1, 0, 0, CS_V, "t3 c1");
        step(0, 1, 1, 0, 0, BZ_V, "t3 c2");
        step(0, 1, 1, 1, 0, BZ_V, "t3 c3");
        step(0, 1, 1, 0, 0, OR_V, "t3 c4");
        step(0, 1, 1, 0, 0, IDLE_V, "t3 c5");

        // 4a: watchdog expiry after 8 COMPUTE cycles, no READ despite M=2
        cfg_wr_beats = 5'd0; cfg_rd_beats = 5'd2;
        step(1, 1, 1, 0, 0, IDLE_V, "t4a c0");
        step(0, 1, 1, 0, 0, CS_V, "t4a c1");
        for (int c = 2; c <= 8; c++) step(0, 1, 1, 0, 0, BZ_V, $sformatf("t4a c%0d", c));
        step(0, 1, 1, 0, 0, ERR_V, "t4a c9");
        step(0, 1, 1, 0, 0, IDLE_V, "t4a c10");
        step(0, 1, 1, 0, 0, IDLE_V, "t4a c11");

        // 4b: done on the expiry cycle wins
        cfg_wr_beats = 5'd0; cfg_rd_beats = 5'd0;
        step(1, 1, 1, 0, 0, IDLE_V, "t4b c0");
        step(0, 1, 1, 0, 0, CS_V, "t4b c1");
        for (int c = 2; c <= 7; c++) step(0, 1, 1, 0, 0, BZ_V, $sformatf("t4b c%0d", c));
        step(0, 1, 1, 1, 0, BZ_V, "t4b c8");
        step(0, 1, 1, 0, 0, OR_V, "t4b c9");
        step(0, 1, 1, 0, 0, IDLE_V, "t4b c10");

        // 5: abort on the 2nd LOAD beat, then restart (start+abort together in IDLE)
        cfg_wr_beats = 5'd4; cfg_rd_beats = 5'd2;
        step(1, 1, 1, 0, 0, IDLE_V, "t5 c0");
        step(0, 1, 1, 0, 0, wr(4'd0), "t5 c1");
        step(0, 1, 1, 0, 1, wr(4'd1), "t5 c2");
        step(0, 1, 1, 0, 0, IDLE_V, "t5 c3");
        step(0, 1, 1, 0, 0, IDLE_V, "t5 c4");
        cfg_wr_beats = 5'd3; cfg_rd_beats = 5'd0;
        step(1, 1, 1, 0, 1, IDLE_V, "t5r c0");
        for (int c = 1; c <= 3; c++) step(0, 1, 1, 0, 0, wr(4'(c - 1)), $sformatf("t5r c%0d", c));
        step(0, 1, 1, 0, 0, CS_V, "t5r c4");
        step(0, 1, 1, 1, 0, BZ_V, "t5r c5");
        step(0, 1, 1, 0, 0, OR_V, "t5r c6");
        step(0, 1, 1, 0, 0, IDLE_V, "t5r c7");

        // 6a: start pulsed during READ and DONE is ignored
        cfg_wr_beats = 5'd0; cfg_rd_beats = 5'd3;
        step(1, 1, 1, 0, 0, IDLE_V, "t6a c0");
        step(0, 1, 1, 0, 0, CS_V, "t6a c1");
        step(0, 1, 1, 1, 0, BZ_V, "t6a c2");
        step(1, 1, 1, 0, 0, rd(4'd0), "t6a c3");
        step(0, 1, 1, 0, 0, rd(4'd1), "t6a c4");
        step(0, 1, 1, 0, 0, rd(4'd2), "t6a c5");
        step(1, 1, 1, 0, 0, OR_V, "t6a c6");
        step(0, 1, 1, 0, 0, IDLE_V, "t6a c7");
        step(0, 1, 1, 0, 0, IDLE_V, "t6a c8");

        // 6b: oversized counts clamp to 16 beats each
        cfg_wr_beats = 5'd31; cfg_rd_beats = 5'd20;
        step(1, 1, 1, 0, 0, IDLE_V, "t6b c0");
        for (int c = 1; c <= 16; c++) step(0, 1, 1, 0, 0, wr(4'(c - 1)), $sformatf("t6b c%0d", c));
        step(0, 1, 1, 0, 0, CS_V, "t6b c17");
        step(0, 1, 1, 1, 0, BZ_V, "t6b c18");
        for (int c = 19; c <= 34; c++) step(0, 1, 1, 0, 0, rd(4'(c - 19)), $sformatf("t6b c%0d", c));
        step(0, 1, 1, 0, 0, OR_V, "t6b c35");
        step(0, 1, 1, 0, 0, IDLE_V, "t6b c36");

        // 6c: asynchronous reset in the middle of COMPUTE
        cfg_wr_beats = 5'd0; cfg_rd_beats = 5'd0;
        step(1, 1, 1, 0, 0, IDLE_V, "t6c c0");
        step(0, 1, 1, 0, 0, CS_V, "t6c c1");
        step(0, 1, 1, 0, 0, BZ_V, "t6c c2");
        @(posedge clk);
        #1;
        check("t6c pre-reset", 32'(obs), 32'(BZ_V));
        reset_n = 1'b0;
        #1;
        check("t6c async outputs", 32'(obs), 32'(IDLE_V));
        check("t6c async state", 32'(state_dbg), 32'(IDLE));
        @(negedge clk);
        reset_n = 1'b1;
        step(0, 1, 1, 1, 0, IDLE_V, "t6c post1");
        step(0, 1, 1, 1, 0, IDLE_V, "t6c post2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
